// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   Clock_t     : clock bundle; base is the only clock, rst is a synchronous
//                 active-high reset.
//   ArbState_t  : arbiter ownership states.
//   BUS_MASTER_*: master indices (0 = data/MEM stage, 1 = instruction fetch).
package bus_arbiter_pkg;

    typedef struct packed {
        logic base;
        logic rst;
    } Clock_t;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } ArbState_t;

    localparam logic BUS_MASTER_DATA = 1'b0;
    localparam logic BUS_MASTER_INST = 1'b1;

endpackage

// File: rtl/bus_if.sv
// Simple request/stall bus between a master and a slave.
//   master modport: drives address, data_wr, mask, read, write;
//                   receives stall, data_rd, data_rd_2, interrupt.
//   slave modport : the mirror image.
interface Bus_if;
    logic [31:0] address;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic        read;
    logic        write;
    logic        stall;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;
    logic [5:0]  interrupt;

    modport master (
        output address, data_wr, mask, read, write,
        input  stall, data_rd, data_rd_2, interrupt
    );

    modport slave (
        input  address, data_wr, mask, read, write,
        output stall, data_rd, data_rd_2, interrupt
    );
endinterface

// File: rtl/bus_rr_picker.sv
// Combinational two-way round-robin pick used while the arbiter is idle.
//   req0, req1 : request from master 0 / master 1
//   rr         : master favoured when both request
//   valid      : at least one request present
//   winner     : chosen master index (meaningful only when valid=1)
module bus_rr_picker (
    input  logic req0,
    input  logic req1,
    input  logic rr,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? rr : req1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with zero added latency.
//   clk : clock bundle (clk.base clock, clk.rst synchronous active-high reset)
//   m0  : data-memory master (CPU MEM stage), slave side of its bus
//   m1  : instruction-fetch master, slave side of its bus
//   bus : shared downstream bus towards the address decoder/slaves
// An uncontended request goes straight through in the same cycle. When the
// slave stalls, ownership is locked to the winner until it completes or
// aborts, so address/data stay stable for the slave.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned RESET_PRIORITY = 0
) (
    input  Clock_t       clk,
    Bus_if.slave         m0,
    Bus_if.slave         m1,
    Bus_if.master        bus
);

    ArbState_t state_q, state_d;
    logic      rr_q, rr_d;

    logic req0, req1;
    logic pick_valid, pick_winner;
    logic win_valid, winner, owner_req;
    logic grant_live, sel_inst;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    bus_rr_picker u_picker (
        .req0   (req0),
        .req1   (req1),
        .rr     (rr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Winner selection. owner_req low in OWNk means the owner abandoned its
    // request; the grant is held but nothing is driven onto the bus.
    always_comb begin
        win_valid = 1'b0;
        winner    = BUS_MASTER_DATA;
        owner_req = 1'b0;
        unique case (state_q)
            OWN0: begin
                win_valid = 1'b1;
                winner    = BUS_MASTER_DATA;
                owner_req = req0;
            end
            OWN1: begin
                win_valid = 1'b1;
                winner    = BUS_MASTER_INST;
                owner_req = req1;
            end
            default: begin
                win_valid = pick_valid;
                winner    = pick_winner;
                owner_req = 1'b1;
            end
        endcase
    end

    assign grant_live = win_valid & owner_req & ~clk.rst;
    assign sel_inst   = win_valid & (winner == BUS_MASTER_INST);

    // Downstream request path; with no winner the m0 fields pass through.
    assign bus.address = sel_inst ? m1.address : m0.address;
    assign bus.data_wr = sel_inst ? m1.data_wr : m0.data_wr;
    assign bus.mask    = sel_inst ? m1.mask    : m0.mask;
    assign bus.read    = grant_live & (sel_inst ? m1.read  : m0.read);
    assign bus.write   = grant_live & (sel_inst ? m1.write : m0.write);

    // Live winner sees the slave stall; anyone else stalls iff requesting.
    assign m0.stall = clk.rst | ((grant_live & ~sel_inst) ? bus.stall : req0);
    assign m1.stall = clk.rst | ((grant_live &  sel_inst) ? bus.stall : req1);

    assign m0.data_rd   = bus.data_rd;
    assign m0.data_rd_2 = bus.data_rd_2;
    assign m0.interrupt = bus.interrupt;
    assign m1.data_rd   = bus.data_rd;
    assign m1.data_rd_2 = bus.data_rd_2;
    assign m1.interrupt = bus.interrupt;

    // The same rules cover IDLE and OWNk: abort drops to IDLE keeping rr,
    // a stall locks/holds ownership, a completion frees the bus and hands
    // priority to the other master.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (win_valid) begin
            if (!owner_req) begin
                state_d = IDLE;
            end else if (bus.stall) begin
                state_d = winner ? OWN1 : OWN0;
            end else begin
                state_d = IDLE;
                rr_d    = ~winner;
            end
        end
    end

    always_ff @(posedge clk.base) begin
        if (clk.rst) begin
            state_q <= IDLE;
            rr_q    <= (RESET_PRIORITY != 0);
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

endmodule
